// File: rtl/mem_access_if.sv
// Byte-wide memory port used by the load/store unit: one byte transfer per
// acknowledged request, little-endian sequencing is handled by the master.
interface mem_access_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_ack_i
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: serialises LB/LH/LW/LBU/LHU/SB/SH/SW onto an 8-bit memory port,
// stalling the pipeline until every byte is acknowledged; other ops pass through.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   aluop_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [31:0]  w_data_i,
  input  logic         w_enable_i,
  input  logic [4:0]   w_addr_i,
  output logic         w_enable_o,
  output logic [4:0]   w_addr_o,
  output logic [31:0]  w_data_o,
  output logic         stall_req_o,
  mem_access_if.master mem
);

  localparam logic [7:0] ME_NOP_OP = 8'h00;
  localparam logic [7:0] EX_LB     = 8'h20;
  localparam logic [7:0] EX_LH     = 8'h21;
  localparam logic [7:0] EX_LW     = 8'h23;
  localparam logic [7:0] EX_LBU    = 8'h24;
  localparam logic [7:0] EX_LHU    = 8'h25;
  localparam logic [7:0] EX_SB     = 8'h28;
  localparam logic [7:0] EX_SH     = 8'h29;
  localparam logic [7:0] EX_SW     = 8'h2B;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wData_q, wData_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  aluOp_q, aluOp_d;
  logic        wEnable_q, wEnable_d;
  logic [4:0]  wAddr_q, wAddr_d;

  function automatic logic isMemOp(input logic [7:0] op);
    case (op)
      EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic isStore(input logic [7:0] op);
    case (op)
      EX_SB, EX_SH, EX_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Index of the final byte of the access, i.e. byte count minus one.
  function automatic logic [1:0] lastByte(input logic [7:0] op);
    case (op)
      EX_LH, EX_LHU, EX_SH: return 2'd1;
      EX_LW, EX_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extendResult(input logic [7:0] op, input logic [31:0] raw);
    case (op)
      EX_LB:   return {{24{raw[7]}}, raw[7:0]};
      EX_LBU:  return {24'd0, raw[7:0]};
      EX_LH:   return {{16{raw[15]}}, raw[15:0]};
      EX_LHU:  return {16'd0, raw[15:0]};
      EX_LW:   return raw;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      byteCnt_q <= 2'd0;
      addr_q    <= 32'd0;
      wData_q   <= 32'd0;
      result_q  <= 32'd0;
      aluOp_q   <= ME_NOP_OP;
      wEnable_q <= 1'b0;
      wAddr_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      addr_q    <= addr_d;
      wData_q   <= wData_d;
      result_q  <= result_d;
      aluOp_q   <= aluOp_d;
      wEnable_q <= wEnable_d;
      wAddr_q   <= wAddr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    byteCnt_d       = byteCnt_q;
    addr_d          = addr_q;
    wData_d         = wData_q;
    result_d        = result_q;
    aluOp_d         = aluOp_q;
    wEnable_d       = wEnable_q;
    wAddr_d         = wAddr_q;
    w_enable_o      = 1'b0;
    w_addr_o        = 5'd0;
    w_data_o        = 32'd0;
    stall_req_o     = 1'b0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = 32'd0;
    mem.mem_wdata_o = 8'd0;

    case (state_q)
      IDLE: begin
        if (isMemOp(aluop_i)) begin
          stall_req_o = 1'b1;
          addr_d      = mem_addr_i;
          wData_d     = w_data_i;
          aluOp_d     = aluop_i;
          wEnable_d   = w_enable_i;
          wAddr_d     = w_addr_i;
          result_d    = 32'd0;
          byteCnt_d   = 2'd0;
          state_d     = ACCESS;
        end else begin
          w_enable_o = w_enable_i && (w_addr_i != 5'd0);
          w_addr_o   = w_addr_i;
          w_data_o   = w_data_i;
        end
      end

      ACCESS: begin
        stall_req_o     = 1'b1;
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = isStore(aluOp_q);
        mem.mem_addr_o  = addr_q + {30'd0, byteCnt_q};
        mem.mem_wdata_o = wData_q[{byteCnt_q, 3'b000} +: 8];
        // Without an ack everything holds, so the same byte is re-presented.
        if (mem.mem_ack_i) begin
          if (!isStore(aluOp_q)) begin
            result_d[{byteCnt_q, 3'b000} +: 8] = mem.mem_rdata_i;
          end
          if (byteCnt_q == lastByte(aluOp_q)) begin
            state_d = DONE;
          end else begin
            byteCnt_d = byteCnt_q + 2'd1;
          end
        end
      end

      DONE: begin
        w_addr_o   = wAddr_q;
        w_enable_o = wEnable_q && !isStore(aluOp_q) && (wAddr_q != 5'd0);
        w_data_o   = extendResult(aluOp_q, result_q);
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset also silences the combinational pass-through path.
    if (!rst) begin
      w_enable_o      = 1'b0;
      w_addr_o        = 5'd0;
      w_data_o        = 32'd0;
      stall_req_o     = 1'b0;
      mem.mem_req_o   = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.mem_addr_o  = 32'd0;
      mem.mem_wdata_o = 8'd0;
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The module SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- aluop_i  in  AluOpBus  operation from EX; one of the EX_LB/LH/LW/LBU/LHU/SB/SH/SW opcodes, or ME_NOP_OP for non-memory instructions.
- mem_addr_i  in  32  byte address of the access.
- w_data_i  in  32  store data for stores; ALU result otherwise.
- w_enable_i  in  1  register write enable from EX.
- w_addr_i  in  RegAddrBus  destination register.
- w_enable_o  out  1  register write enable to writeback.
- w_addr_o  out  RegAddrBus  destination register to writeback.
- w_data_o  out  32  writeback data.
- stall_req_o  out  1  pipeline stall request.
- mem_req_o  out  1  byte transfer request to memory.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  byte address on the memory port.
- mem_wdata_o  out  8  write byte.
- mem_rdata_i  in  8  read byte; valid in the cycle mem_ack_i=1.
- mem_ack_i  in  1  the current byte completes this cycle.

Function
REQ-002 States: IDLE, ACCESS, DONE; reset state IDLE.
REQ-003 IDLE with aluop_i = ME_NOP_OP: combinational pass-through with zero latency: w_enable_o=w_enable_i, w_addr_o=w_addr_i, w_data_o=w_data_i; stall_req_o=0.
REQ-004 IDLE with a memory op:
- stall_req_o=1.
- w_enable_o=0.
- Latch mem_addr_i, w_data_i, aluop_i, w_enable_i and w_addr_i.
- byte_cnt<=0; next state ACCESS.
REQ-005 Byte count N: 1 for B/BU, 2 for H/HU, 4 for W.
REQ-006 ACCESS:
- mem_req_o=1; mem_addr_o = latched addr + byte_cnt (32-bit wrap).
- mem_we_o=1 for stores, 0 for loads.
- mem_wdata_o = latched store data byte [8*byte_cnt+7 : 8*byte_cnt] (little-endian).
- stall_req_o=1; w_enable_o=0.
REQ-007 ACCESS with mem_ack_i=1:
- Loads capture mem_rdata_i into result byte byte_cnt.
- If byte_cnt = N-1, go to DONE; otherwise increment byte_cnt.
REQ-008 ACCESS with mem_ack_i=0: hold state; address, data and byte_cnt unchanged.
REQ-009 Outside ACCESS: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-010 DONE:
- Lasts exactly one cycle, then returns to IDLE; stall_req_o=0.
- w_addr_o = latched w_addr_i.
- w_enable_o = latched w_enable_i for loads, 0 for stores.
REQ-011 DONE w_data_o:
- LB/LH sign-extend bit 7/15.
- LBU/LHU zero-extend.
- LW returns all 4 bytes.
- Stores: 0.
REQ-012 Latency with mem_ack_i=1 every cycle: N+2 cycles from the memory op appearing in IDLE to DONE, i.e. 6 cycles for LW.
REQ-013 Alignment is not checked; misaligned accesses are performed byte-serially at consecutive addresses.
REQ-014 Writeback to register x0 is suppressed: w_enable_o=0 whenever w_addr_o=0.
REQ-015 Inputs are ignored while in ACCESS and DONE; the upstream pipeline holds them stable under stall.

Reset
REQ-016 While rst=0, regardless of clock:
- state=IDLE, byte_cnt=0, all latches 0.
- All outputs 0, including stall_req_o and mem_req_o.
REQ-017 Reset asserted mid-ACCESS abandons the transfer with no further memory requests; bytes already written stay written.
REQ-018 After rst returns to 1, a pending memory op restarts from byte 0.

Verification
REQ-019 LW addr 0x100, memory 78,56,34,12, ack every cycle:
- mem_addr_o 0x100..0x103 in 4 consecutive cycles.
- stall_req_o high 5 cycles.
- DONE: w_data_o=0x12345678, w_enable_o=1.
REQ-020 LB returning byte 0x80 gives w_data_o=0xFFFFFF80; LBU returning 0x80 gives 0x00000080; LH returning 0x34,0x92 gives 0xFFFF9234.
REQ-021 SH addr 0x202 data 0xDEADBEEF:
- Writes 0xEF@0x202, then 0xBE@0x203, with mem_we_o=1.
- w_enable_o=0 throughout; DONE w_data_o=0.
REQ-022 LW with mem_ack_i low for 3 cycles on byte 1: mem_addr_o holds 0x101 for 4 cycles, stall_req_o held, final result unchanged.
REQ-023 rst pulsed low during byte 2 of LW:
- Immediately: mem_req_o=0, stall_req_o=0.
- After release: state IDLE, then restart at 0x100.
REQ-024 ME_NOP_OP with w_data_i=0x5, w_addr_i=3, w_enable_i=1: same-cycle w_data_o=0x5, w_addr_o=3, w_enable_o=1, stall_req_o=0, mem_req_o=0; with w_addr_i=0, w_enable_o=0.
